rx_stream_sequencer: RTL and testbench
======================================

Name: rx_stream_sequencer

Overview:
- Sequences the `run`/`eob` controls of the RX sample framer from host stream commands.
- Accepts commands of the form "N lines now" or "N lines at time T", with chain/reload/stop modifiers.
- Gates framer input on the correct sample clock edge and terminates each burst with `eob` on the last sample.
- Reports late-command, broken-chain, overrun and bad-command errors with the timestamp of detection.
- Sits between the command FIFO / settings bus and the framer, sharing its `clk`, `strobe` and `vita_time`.

Parameters:
- NUM_LINES_W, 28, width of the per-command sample count field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush; same effect as `reset` on state and outputs.
- vita_time  in  64  free-running timestamp, same domain as the framer.
- cmd_tdata  in  32  [31]=send_imm, [30]=chain, [29]=reload, [28]=stop, [27:0]=num_lines.
- cmd_time  in  64  start time, qualified with cmd_tdata.
- cmd_tvalid  in  1  command available.
- cmd_tready  out  1  command consumed this cycle.
- strobe  in  1  sample-valid from the DSP chain.
- full  in  1  framer back-pressure.
- run  out  1  framer enable.
- eob  out  1  end-of-burst marker to the framer, meaningful only with run & strobe.
- busy  out  1  high in any state except IDLE.
- err_valid  out  1  error record valid.
- err_code  out  3  1=LATE, 2=BROKEN_CHAIN, 3=OVERRUN, 4=BAD_CMD.
- err_time  out  64  vita_time captured at detection.
- err_ready  in  1  error consumer accept.

Behaviour:
- Reset/clear values: state=IDLE, run=0, eob=0, cmd_tready=0, busy=0, err_valid=0, err_code=0, err_time=0, lines_left=0. Any burst in progress is abandoned and no eob is emitted.
- States: IDLE, WAIT_TIME, RUNNING, ERROR.
- Registered fields: cur_cmd = {chain, reload, num_lines}; lines_left is NUM_LINES_W bits.
- IDLE:
  - cmd_tready = cmd_tvalid.
  - On accept with stop=1: command discarded, stay IDLE.
  - On accept with num_lines=0 and stop=0: go to ERROR, code BAD_CMD.
  - Otherwise: latch the command and set lines_left=num_lines. send_imm=1 goes to RUNNING next cycle; send_imm=0 goes to WAIT_TIME.
- WAIT_TIME:
  - vita_time == cmd_time goes to RUNNING.
  - vita_time > cmd_time (unsigned) goes to ERROR, code LATE. No sample is passed.
  - A stop command arriving here is accepted (cmd_tready=1) and returns to IDLE with no eob.
- RUNNING:
  - run=1 combinationally.
  - Each strobe with full=0 decrements lines_left.
  - strobe with full=1 goes to ERROR, code OVERRUN. In that cycle run is still 1 and eob=1, so the framer closes the packet.
  - Last sample is lines_left==1 & strobe & ~full.
    - reload=1: lines_left reloads to num_lines, no eob, stay RUNNING.
    - chain=1 and cmd_tvalid with stop=0: pop it (cmd_tready=1 same cycle), load num_lines, no eob, stay RUNNING regardless of its send_imm/time.
    - chain=1 and no cmd_tvalid: eob=1, go to ERROR, code BROKEN_CHAIN.
    - chain=0: eob=1, go to IDLE.
  - Stop command arriving while RUNNING is accepted immediately. The next qualifying strobe carries eob=1, then go to IDLE. If no strobe occurs, remain RUNNING with a stop_pending flag.
  - Stop takes precedence over reload and chain on the same strobe.
- ERROR:
  - err_valid=1 with err_code/err_time stable until err_ready; then return to IDLE.
  - run=0; cmd_tready=0.
- eob is combinational and asserted only when run & strobe.
- Latency: send_imm command accepted in cycle N gives run=1 from cycle N+1. Timed start gives run=1 the cycle after the equality match.
- Arithmetic: time compare is 64-bit unsigned. lines_left never wraps, since 0 is rejected and the counter is reloaded or left at exit.
- Simultaneous reset and any event: reset wins.

Test Plan:
- Immediate burst: cmd send_imm=1, num_lines=5, then 5 strobes on consecutive cycles → run high for exactly 5 strobes; eob only on the 5th; busy falls the next cycle; no error.
- Timed start: cmd_time=1000, vita_time counting from 990 → run rises the cycle after vita_time==1000. Same command with vita_time already at 1001 → err_code=1, err_time=1001, run never high.
- Chain: cmd A num_lines=3 with chain=1, cmd B num_lines=2 queued → 5 contiguous samples, single eob on sample 5. Without B queued → eob on sample 3, err_code=2.
- Overrun: 10-line burst with full=1 at the 4th strobe → eob=1 that cycle, err_code=3, run=0 afterwards. err_valid is held while err_ready=0 and clears one cycle after err_ready.
- Reload + stop: num_lines=4 with reload=1 runs past 12 samples with no eob. A stop command accepted mid-burst → eob on the next strobe, then IDLE.
- BAD_CMD and reset: num_lines=0 → err_code=4. Reset asserted mid-burst → run=0, eob=0, err_valid=0 the next cycle.

Source files
------------

// File: rtl/rx_stream_sequencer.sv
// rx_stream_sequencer: drives the RX framer run/eob controls from host stream
// commands ("N lines now" / "N lines at time T", with chain/reload/stop), and
// reports LATE / BROKEN_CHAIN / OVERRUN / BAD_CMD errors with a timestamp.
module rx_stream_sequencer #(
  parameter int unsigned NUM_LINES_W = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [63:0] vita_time,
  input  logic [31:0] cmd_tdata,
  input  logic [63:0] cmd_time,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  input  logic        strobe,
  input  logic        full,
  output logic        run,
  output logic        eob,
  output logic        busy,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [63:0] err_time,
  input  logic        err_ready
);

  typedef enum logic [1:0] {IDLE, WAIT_TIME, RUNNING, ERROR} state_t;

  localparam logic [2:0] ERR_LATE   = 3'd1;
  localparam logic [2:0] ERR_BROKEN = 3'd2;
  localparam logic [2:0] ERR_OVERRN = 3'd3;
  localparam logic [2:0] ERR_BADCMD = 3'd4;

  state_t                 state, state_next;
  logic                   chain_r, reload_r;
  logic [NUM_LINES_W-1:0] num_r;
  logic [63:0]            time_r;
  logic [NUM_LINES_W-1:0] lines_left, lines_next;
  logic                   stop_pending, stop_pending_next;
  logic                   load_cmd;
  logic                   set_err;
  logic [2:0]             err_code_next;

  // Command field decode
  logic                   cmd_imm, cmd_chain, cmd_reload, cmd_stop;
  logic [NUM_LINES_W-1:0] cmd_lines;
  assign cmd_imm    = cmd_tdata[31];
  assign cmd_chain  = cmd_tdata[30];
  assign cmd_reload = cmd_tdata[29];
  assign cmd_stop   = cmd_tdata[28];
  assign cmd_lines  = cmd_tdata[NUM_LINES_W-1:0];

  // Shared RUNNING-state conditions used by both next-state and output logic
  logic stop_in, strobe_ok, last, stopping, chain_next, chain_ok, burst_end, chain_pop;
  assign stop_in    = cmd_tvalid & cmd_stop;
  assign strobe_ok  = strobe & ~full;
  assign last       = (lines_left == NUM_LINES_W'(1));
  assign stopping   = stop_pending | stop_in;
  assign chain_next = chain_r & cmd_tvalid & ~cmd_stop;
  assign chain_ok   = chain_next & (cmd_lines != '0);
  // Stop outranks reload/chain; a chained zero-length command ends the burst too
  assign burst_end  = strobe & (full | stopping | (last & ~reload_r & ~chain_ok));
  assign chain_pop  = strobe_ok & ~stopping & last & ~reload_r & chain_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_next;
  end

  // Command, counter and error-record registers
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      chain_r      <= 1'b0;
      reload_r     <= 1'b0;
      num_r        <= '0;
      time_r       <= '0;
      lines_left   <= '0;
      stop_pending <= 1'b0;
      err_code     <= '0;
      err_time     <= '0;
    end else begin
      lines_left   <= lines_next;
      stop_pending <= stop_pending_next;
      if (load_cmd) begin
        chain_r  <= cmd_chain;
        reload_r <= cmd_reload;
        num_r    <= cmd_lines;
        time_r   <= cmd_time;
      end
      if (set_err) begin
        err_code <= err_code_next;
        err_time <= vita_time;
      end
    end
  end

  // Next-state and datapath-update decisions
  always_comb begin
    state_next        = state;
    lines_next        = lines_left;
    stop_pending_next = stop_pending;
    load_cmd          = 1'b0;
    set_err           = 1'b0;
    err_code_next     = err_code;
    unique case (state)
      IDLE: begin
        stop_pending_next = 1'b0;
        if (cmd_tvalid && !cmd_stop) begin
          if (cmd_lines == '0) begin
            state_next    = ERROR;
            set_err       = 1'b1;
            err_code_next = ERR_BADCMD;
          end else begin
            load_cmd   = 1'b1;
            lines_next = cmd_lines;
            state_next = cmd_imm ? RUNNING : WAIT_TIME;
          end
        end
      end
      WAIT_TIME: begin
        if (stop_in) begin
          state_next = IDLE;
        end else if (vita_time == time_r) begin
          state_next = RUNNING;
        end else if (vita_time > time_r) begin
          state_next    = ERROR;
          set_err       = 1'b1;
          err_code_next = ERR_LATE;
        end
      end
      RUNNING: begin
        if (stop_in) stop_pending_next = 1'b1;
        if (strobe) begin
          if (full) begin
            state_next        = ERROR;
            set_err           = 1'b1;
            err_code_next     = ERR_OVERRN;
            stop_pending_next = 1'b0;
          end else if (stopping) begin
            state_next        = IDLE;
            stop_pending_next = 1'b0;
          end else if (last) begin
            if (reload_r) begin
              lines_next = num_r;
            end else if (chain_next) begin
              if (chain_ok) begin
                load_cmd   = 1'b1;
                lines_next = cmd_lines;
              end else begin
                state_next    = ERROR;
                set_err       = 1'b1;
                err_code_next = ERR_BADCMD;
              end
            end else if (chain_r) begin
              state_next    = ERROR;
              set_err       = 1'b1;
              err_code_next = ERR_BROKEN;
            end else begin
              state_next = IDLE;
            end
          end else begin
            lines_next = lines_left - NUM_LINES_W'(1);
          end
        end
      end
      ERROR: begin
        if (err_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Framer controls, handshakes and status
  always_comb begin
    run        = (state == RUNNING);
    eob        = run & burst_end;
    busy       = (state != IDLE);
    err_valid  = (state == ERROR);
    cmd_tready = 1'b0;
    unique case (state)
      IDLE:      cmd_tready = cmd_tvalid;
      WAIT_TIME: cmd_tready = stop_in;
      RUNNING:   cmd_tready = stop_in | chain_pop;
      default:   cmd_tready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rx_stream_sequencer.sv
// Directed self-checking bench for rx_stream_sequencer.
module tb_rx_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [63:0] vita_time = 64'd0;
  logic [31:0] cmd_tdata = 32'd0;
  logic [63:0] cmd_time = 64'd0;
  logic        cmd_tvalid = 1'b0;
  logic        cmd_tready;
  logic        strobe = 1'b0;
  logic        full = 1'b0;
  logic        run, eob, busy, err_valid;
  logic [2:0]  err_code;
  logic [63:0] err_time;
  logic        err_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic vt_inc = 1'b0;

  rx_stream_sequencer #(.NUM_LINES_W(28)) dut (
    .clk(clk), .reset(reset), .clear(clear), .vita_time(vita_time),
    .cmd_tdata(cmd_tdata), .cmd_time(cmd_time), .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready), .strobe(strobe), .full(full), .run(run),
    .eob(eob), .busy(busy), .err_valid(err_valid), .err_code(err_code),
    .err_time(err_time), .err_ready(err_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (vt_inc) vita_time = vita_time + 64'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic imm, input logic chn, input logic rld,
                                     input logic stp, input logic [27:0] n);
    return {imm, chn, rld, stp, n};
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_run", run, 1'b0);
    chk("rst_eob", eob, 1'b0);
    chk("rst_tready", cmd_tready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errv", err_valid, 1'b0);
    chk("rst_code", err_code, 3'd0);
    chk("rst_time", err_time, 64'd0);

    // Immediate burst of 5
    cmd_tdata = mk(1, 0, 0, 0, 28'd5); cmd_tvalid = 1'b1;
    #1;
    chk("imm_tready", cmd_tready, 1'b1);
    chk("imm_run0", run, 1'b0);
    tick();
    cmd_tvalid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      strobe = 1'b1;
      #1;
      chk("imm_run", run, 1'b1);
      chk("imm_eob", eob, (i == 5));
      tick();
    end
    strobe = 1'b0;
    #1;
    chk("imm_busy_end", busy, 1'b0);
    chk("imm_run_end", run, 1'b0);
    chk("imm_noerr", err_valid, 1'b0);

    // Timed start at 1000 with vita_time counting from 990
    vita_time = 64'd990; vt_inc = 1'b1;
    cmd_tdata = mk(0, 0, 0, 0, 28'd2); cmd_time = 64'd1000; cmd_tvalid = 1'b1;
    #1;
    chk("ts_tready", cmd_tready, 1'b1);
    tick();
    cmd_tvalid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("ts_wait_run", run, 1'b0);
      chk("ts_wait_busy", busy, 1'b1);
      tick();
    end
    #1;
    chk("ts_eq_run", run, 1'b0);
    tick();
    vt_inc = 1'b0;
    #1;
    chk("ts_started", run, 1'b1);
    strobe = 1'b1;
    #1;
    chk("ts_eob1", eob, 1'b0);
    tick();
    #1;
    chk("ts_eob2", eob, 1'b1);
    tick();
    strobe = 1'b0;
    #1;
    chk("ts_idle", busy, 1'b0);

    // Late command: vita_time already past the start time
    vita_time = 64'd1001;
    cmd_tdata = mk(0, 0, 0, 0, 28'd2); cmd_time = 64'd1000; cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    #1;
    chk("late_run_wait", run, 1'b0);
    tick();
    #1;
    chk("late_errv", err_valid, 1'b1);
    chk("late_code", err_code, 3'd1);
    chk("late_time", err_time, 64'd1001);
    chk("late_run", run, 1'b0);
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    #1;
    chk("late_clr", err_valid, 1'b0);

    // Chain A(3) -> B(2): five contiguous samples, one eob
    cmd_tdata = mk(1, 1, 0, 0, 28'd3); cmd_tvalid = 1'b1;
    tick();
    cmd_tdata = mk(1, 0, 0, 0, 28'd2);
    for (int i = 1; i <= 5; i++) begin
      strobe = 1'b1;
      #1;
      chk("ch_run", run, 1'b1);
      chk("ch_eob", eob, (i == 5));
      chk("ch_tready", cmd_tready, (i == 3));
      tick();
      if (i == 3) cmd_tvalid = 1'b0;
    end
    strobe = 1'b0;
    #1;
    chk("ch_idle", busy, 1'b0);
    chk("ch_noerr", err_valid, 1'b0);

    // Broken chain: A(3) with nothing queued
    vita_time = 64'h1234;
    cmd_tdata = mk(1, 1, 0, 0, 28'd3); cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      strobe = 1'b1;
      #1;
      chk("bc_eob", eob, (i == 3));
      tick();
    end
    strobe = 1'b0;
    #1;
    chk("bc_errv", err_valid, 1'b1);
    chk("bc_code", err_code, 3'd2);
    chk("bc_time", err_time, 64'h1234);
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;

    // Overrun on the 4th strobe of a 10-line burst
    cmd_tdata = mk(1, 0, 0, 0, 28'd10); cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      strobe = 1'b1; full = (i == 4);
      #1;
      chk("ov_run", run, 1'b1);
      chk("ov_eob", eob, (i == 4));
      tick();
    end
    strobe = 1'b0; full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ov_run_off", run, 1'b0);
      chk("ov_errv_hold", err_valid, 1'b1);
      chk("ov_code", err_code, 3'd3);
      tick();
    end
    err_ready = 1'b1;
    #1;
    chk("ov_errv_ack", err_valid, 1'b1);
    tick();
    err_ready = 1'b0;
    #1;
    chk("ov_errv_clr", err_valid, 1'b0);

    // Reload (4 lines) runs past 12 samples, then stop mid-burst
    cmd_tdata = mk(1, 0, 1, 0, 28'd4); cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      strobe = 1'b1;
      #1;
      chk("rl_run", run, 1'b1);
      chk("rl_eob", eob, 1'b0);
      tick();
    end
    strobe = 1'b0;
    cmd_tdata = mk(0, 0, 0, 1, 28'd0); cmd_tvalid = 1'b1;
    #1;
    chk("st_tready", cmd_tready, 1'b1);
    chk("st_eob0", eob, 1'b0);
    tick();
    cmd_tvalid = 1'b0;
    #1;
    chk("st_pending_run", run, 1'b1);
    chk("st_pending_eob", eob, 1'b0);
    tick();
    strobe = 1'b1;
    #1;
    chk("st_eob", eob, 1'b1);
    tick();
    strobe = 1'b0;
    #1;
    chk("st_idle", busy, 1'b0);
    chk("st_run_off", run, 1'b0);

    // Zero-length command
    cmd_tdata = mk(1, 0, 0, 0, 28'd0); cmd_tvalid = 1'b1;
    #1;
    chk("bad_tready", cmd_tready, 1'b1);
    tick();
    cmd_tvalid = 1'b0;
    #1;
    chk("bad_errv", err_valid, 1'b1);
    chk("bad_code", err_code, 3'd4);
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;

    // Reset mid-burst
    cmd_tdata = mk(1, 0, 0, 0, 28'd5); cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
    strobe = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    #1;
    chk("mr_run", run, 1'b0);
    chk("mr_eob", eob, 1'b0);
    chk("mr_errv", err_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    reset = 1'b0; strobe = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
